puzzle_bank_selector: RTL
=========================

Name: puzzle_bank_selector

Overview:
- Picks one puzzle (cell map plus visibility mask) from a flat bank of NUM_LEVELS × MAPS_PER_LEVEL entries, driven by a requested difficulty level.
- Sits between the map definition block and the game controller.
- Uses an internal free-running LFSR to draw an index with rejection sampling, so the draw is uniform over the level.
- Never serves the same map twice in a row for a level.
- Registers the chosen puzzle behind a req/done handshake.

Parameters:
- NUM_LEVELS, 2, number of difficulty levels
- MAPS_PER_LEVEL, 15, maps per level (≥2)
- CELLS, 81, cells per puzzle
- CELL_BITS, 4, bits per cell value
- VIS_BITS, 2, bits per cell visibility code
- LFSR_WIDTH, 8, random generator width (2^LFSR_WIDTH ≥ MAPS_PER_LEVEL)
- LFSR_SEED, 8'hA5, nonzero reset seed
- MAX_RETRY, 7, rejected draws allowed before fallback

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  start a selection; sampled only in IDLE
- level  in  clog2(NUM_LEVELS) (min 1)  requested difficulty, latched on accepted req
- maps  in  NUM_LEVELS*MAPS_PER_LEVEL*CELLS*CELL_BITS  flattened map bank; entry i at [i*CELLS*CELL_BITS +: CELLS*CELL_BITS]
- visibilities  in  NUM_LEVELS*MAPS_PER_LEVEL*CELLS*VIS_BITS  flattened visibility bank, same indexing
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse when outputs update
- selected_index  out  clog2(NUM_LEVELS*MAPS_PER_LEVEL)  global index of the current puzzle
- selected_map  out  CELLS*CELL_BITS  registered map
- selected_visibility  out  CELLS*VIS_BITS  registered visibility

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; LFSR loads LFSR_SEED.
  - All outputs are 0.
  - last_local[l] = all-ones sentinel ("none") for every level.
  - Retry counter is 0.
- LFSR:
  - Maximal-length Galois LFSR. Advances every cycle regardless of state.
  - Never holds zero. If it ever reads zero, it reloads LFSR_SEED.
- IDLE:
  - req=1 latches lvl = min(level, NUM_LEVELS-1), clears the retry counter, and moves to DRAW.
  - req is ignored in every other state; no queueing.
- DRAW (one cycle per attempt):
  - cand = low clog2(MAPS_PER_LEVEL) bits of the LFSR.
  - The candidate is rejected if cand ≥ MAPS_PER_LEVEL or cand == last_local[lvl].
  - On reject with retry < MAX_RETRY: increment retry and stay in DRAW.
  - On reject with retry == MAX_RETRY: cand = (last_local[lvl]+1) mod MAPS_PER_LEVEL. If last_local[lvl] is the sentinel, cand = 0 instead. Then go to LOAD.
  - On accept: go to LOAD.
- LOAD (one cycle):
  - gidx = lvl*MAPS_PER_LEVEL + cand, computed at full index width with no truncation.
  - Registers selected_map, selected_visibility and selected_index from gidx.
  - Writes last_local[lvl] = cand, pulses done, and returns to IDLE.
- Latency: req → done takes 2 + retries cycles, with a worst case of MAX_RETRY+2.
- Output hold: outputs hold their value between selections and change only in LOAD.
- Bank inputs: maps and visibilities are treated as static. The values sampled in the LOAD cycle are the ones used.
- Reset mid-operation: aborts any draw immediately, with no done pulse. History returns to the sentinel.
- Back-to-back: req held high continuously causes a new selection to start on the cycle after done.

Decomposition:
- Shared package puzzle_pkg:
  - FSM state enum (IDLE, DRAW, LOAD).
  - Index-width helper functions: LVL_W, LOC_W, GIDX_W.
  - Default bank geometry constants (CELLS=81, CELL_BITS=4, VIS_BITS=2).
- Sub-module lfsr_gen:
  - Parameters: WIDTH, SEED.
  - Ports: clk, reset, value.
  - Tap table held in the package, per width.

Test Plan:
- Reset: hold reset=0, then release. Required: outputs 0, busy=0, done=0; LFSR equals 8'hA5 on the first cycle after release.
- Basic draw: bank entry i has every cell = i[3:0]; req with level=1. Required: done within ≤9 cycles, selected_index in 15..29, selected_map = its bank entry.
- No-repeat: 200 consecutive reqs at level=0. Required: selected_index never equals its previous value; all 15 indices are hit at least once.
- Out-of-range level (NUM_LEVELS=3, level=2'd3). Required: the request behaves as level 2, selected_index in 30..44.
- Forced fallback: force the LFSR output to a constant 8'hFF. Required: after MAX_RETRY=7 rejects, cand = (last+1) mod 15; done arrives at cycle 9; from sentinel history the result is index 0 at level 0.
- Reset mid-DRAW: assert reset 1 cycle after req. Required: no done pulse, outputs 0; the next req still succeeds with history cleared.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared types and geometry helpers for the puzzle bank selector and its LFSR.
package puzzle_pkg;

    localparam int DEF_CELLS     = 81;
    localparam int DEF_CELL_BITS = 4;
    localparam int DEF_VIS_BITS  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        LOAD = 2'd2
    } state_e;

    function automatic int lvl_w(input int num_levels);
        return (num_levels > 1) ? $clog2(num_levels) : 1;
    endfunction

    function automatic int loc_w(input int maps_per_level);
        return (maps_per_level > 1) ? $clog2(maps_per_level) : 1;
    endfunction

    function automatic int gidx_w(input int num_levels, input int maps_per_level);
        return (num_levels * maps_per_level > 1) ? $clog2(num_levels * maps_per_level) : 1;
    endfunction

    // Right-shifting Galois feedback masks; bit k set means tap x^(k+1).
    // Widths without an entry are unsupported and return zero.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/puzzle_bank_selector_if.sv
// Request/response bundle between the game controller (master) and the selector (slave).
interface puzzle_bank_selector_if
    import puzzle_pkg::*;
#(
    parameter int NUM_LEVELS     = 2,
    parameter int MAPS_PER_LEVEL = 15,
    parameter int CELLS          = DEF_CELLS,
    parameter int CELL_BITS      = DEF_CELL_BITS,
    parameter int VIS_BITS       = DEF_VIS_BITS
);
    localparam int LVL_W  = lvl_w(NUM_LEVELS);
    localparam int GIDX_W = gidx_w(NUM_LEVELS, MAPS_PER_LEVEL);

    logic                        req;
    logic [LVL_W-1:0]            level;
    logic                        busy;
    logic                        done;
    logic [GIDX_W-1:0]           selected_index;
    logic [CELLS*CELL_BITS-1:0]  selected_map;
    logic [CELLS*VIS_BITS-1:0]   selected_visibility;

    modport master (
        output req, level,
        input  busy, done, selected_index, selected_map, selected_visibility
    );

    modport slave (
        input  req, level,
        output busy, done, selected_index, selected_map, selected_visibility
    );
endinterface

// File: rtl/lfsr_gen.sv
// Free-running maximal-length Galois LFSR that self-recovers from the all-zero lockup state.
module lfsr_gen
    import puzzle_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'('hA5)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        if (value_q == '0) begin
            value_d = SEED;
        end else if (value_q[0]) begin
            value_d = (value_q >> 1) ^ TAPS;
        end else begin
            value_d = value_q >> 1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/puzzle_bank_selector.sv
// Draws a non-repeating puzzle of the requested level from a flat bank and registers it behind req/done.
module puzzle_bank_selector
    import puzzle_pkg::*;
#(
    parameter int                    NUM_LEVELS     = 2,
    parameter int                    MAPS_PER_LEVEL = 15,
    parameter int                    CELLS          = DEF_CELLS,
    parameter int                    CELL_BITS      = DEF_CELL_BITS,
    parameter int                    VIS_BITS       = DEF_VIS_BITS,
    parameter int                    LFSR_WIDTH     = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = LFSR_WIDTH'('hA5),
    parameter int                    MAX_RETRY      = 7
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [NUM_LEVELS*MAPS_PER_LEVEL*CELLS*CELL_BITS-1:0] maps,
    input  logic [NUM_LEVELS*MAPS_PER_LEVEL*CELLS*VIS_BITS-1:0]  visibilities,
    puzzle_bank_selector_if.slave                                bus
);
    localparam int LVL_W  = lvl_w(NUM_LEVELS);
    localparam int LOC_W  = loc_w(MAPS_PER_LEVEL);
    localparam int GIDX_W = gidx_w(NUM_LEVELS, MAPS_PER_LEVEL);
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int MAP_W  = CELLS * CELL_BITS;
    localparam int VIS_W  = CELLS * VIS_BITS;
    localparam logic [LOC_W-1:0] SENTINEL = '1;

    state_e            state_q, state_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d, level_clamped;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [LOC_W-1:0]  cand_q, cand_d;
    logic [LOC_W-1:0]  last_q [NUM_LEVELS];
    logic [LOC_W-1:0]  draw, last_cur, fallback;
    logic              reject, load_en;
    logic              done_q;
    logic [GIDX_W-1:0] index_q, gidx;
    logic [MAP_W-1:0]  map_q, bank_map;
    logic [VIS_W-1:0]  vis_q, bank_vis;
    logic [LFSR_WIDTH-1:0] rnd;
    logic              unused_rnd;

    lfsr_gen #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (rnd)
    );

    // Only the low bits form the candidate; the rest just keep the sequence long.
    assign unused_rnd = ^rnd;
    assign draw       = rnd[LOC_W-1:0];
    assign last_cur   = last_q[lvl_q];
    assign reject     = (int'(draw) >= MAPS_PER_LEVEL) || (draw == last_cur);

    always_comb begin
        fallback = last_cur + 1'b1;
        if (last_cur == SENTINEL || int'(last_cur) >= MAPS_PER_LEVEL - 1) begin
            fallback = '0;
        end
    end

    always_comb begin
        level_clamped = bus.level;
        if (int'(bus.level) > NUM_LEVELS - 1) begin
            level_clamped = LVL_W'(NUM_LEVELS - 1);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        retry_d = retry_q;
        cand_d  = cand_q;
        load_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    lvl_d   = level_clamped;
                    retry_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (!reject) begin
                    cand_d  = draw;
                    state_d = LOAD;
                end else if (int'(retry_q) < MAX_RETRY) begin
                    retry_d = retry_q + 1'b1;
                end else begin
                    cand_d  = fallback;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gidx     = GIDX_W'(lvl_q) * GIDX_W'(MAPS_PER_LEVEL) + GIDX_W'(cand_q);
    assign bank_map = maps[int'(gidx) * MAP_W +: MAP_W];
    assign bank_vis = visibilities[int'(gidx) * VIS_W +: VIS_W];

    // NOTE: the per-level history is a tiny array that must restart at "none", so it is reset like any flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            retry_q <= '0;
            cand_q  <= '0;
            done_q  <= 1'b0;
            index_q <= '0;
            map_q   <= '0;
            vis_q   <= '0;
            for (int l = 0; l < NUM_LEVELS; l++) begin
                last_q[l] <= SENTINEL;
            end
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            retry_q <= retry_d;
            cand_q  <= cand_d;
            done_q  <= load_en;
            if (load_en) begin
                index_q       <= gidx;
                map_q         <= bank_map;
                vis_q         <= bank_vis;
                last_q[lvl_q] <= cand_q;
            end
        end
    end

    assign bus.busy                = (state_q != IDLE);
    assign bus.done                = done_q;
    assign bus.selected_index      = index_q;
    assign bus.selected_map        = map_q;
    assign bus.selected_visibility = vis_q;
endmodule
